seq_step4: RTL and testbench

Programmable 4-bit sequence generator that is the upstream stage of the 4-bit data-stop block. It produces the 4-bit code `b` and the enable `en` the data-stop stage consumes, stepping the code between programmable bounds at a programmable rate. It supports up, down, bounce and single-shot patterns, plus pause (hold), stop and restart control.

---
 rtl/seq_step4_pkg.sv | 21 ++
 rtl/seq_step4_step_tick.sv | 31 +++
 rtl/seq_step4.sv | 162 ++++++++++++++++
 tb/tb_seq_step4.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_step4_pkg.sv
// Shared types and constants for the seq_step4 code sequencer.
// Imported by the prescaler and the top-level FSM.
package seq_step4_pkg;

  localparam int CODE_W = 4;

  typedef enum logic [1:0] {
    M_UP     = 2'b00,
    M_DOWN   = 2'b01,
    M_BOUNCE = 2'b10,
    M_SINGLE = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HOLD,
    S_DONE
  } state_t;

endpackage

// File: rtl/seq_step4_step_tick.sv
// Step-period prescaler: counts RUN cycles and flags when a code
// has been held for period+1 cycles.
module step_tick #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic             adv,
  input  logic [DIV_W-1:0] period,
  output logic             tick
);

  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] cnt;

  assign tick = (cnt == period_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      period_q <= '0;
      cnt      <= '0;
    end else if (load) begin
      period_q <= period;
      cnt      <= '0;
    end else if (adv) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/seq_step4.sv
// Programmable 4-bit code sequencer feeding the data-stop stage.
// Holds the FSM, code register, bounce direction and latched bounds.
module seq_step4
  import seq_step4_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              stop,
  input  logic              hold,
  input  logic [1:0]        mode,
  input  logic [CODE_W-1:0] lo,
  input  logic [CODE_W-1:0] hi,
  input  logic [DIV_W-1:0]  period,
  output logic [CODE_W-1:0] b,
  output logic              en,
  output logic              busy,
  output logic              wrap,
  output logic              done,
  output logic              err
);

  state_t            st, st_n;
  mode_t             mode_q;
  logic [CODE_W-1:0] lo_q, hi_q, b_n;
  logic              dir_up, dir_n;
  logic              wrap_n, done_n, err_n;
  logic              load, adv, tick;

  step_tick #(
    .DIV_W (DIV_W)
  ) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .adv     (adv),
    .period  (period),
    .tick    (tick)
  );

  always_comb begin
    st_n   = st;
    b_n    = b;
    dir_n  = dir_up;
    wrap_n = 1'b0;
    done_n = 1'b0;
    err_n  = 1'b0;
    load   = 1'b0;
    adv    = 1'b0;
    if (stop) begin
      st_n = S_IDLE;
    end else if (start) begin
      if (lo > hi) begin
        st_n  = S_IDLE;
        err_n = 1'b1;
      end else begin
        load  = 1'b1;
        st_n  = S_RUN;
        b_n   = (mode == M_DOWN) ? hi : lo;
        dir_n = (mode != M_DOWN);
      end
    end else begin
      unique case (st)
        S_RUN: begin
          if (hold) begin
            st_n = S_HOLD;
          end else begin
            adv = 1'b1;
            if (tick) begin
              unique case (mode_q)
                M_UP: begin
                  if (b == hi_q) begin
                    b_n    = lo_q;
                    wrap_n = 1'b1;
                  end else begin
                    b_n = b + 1'b1;
                  end
                end
                M_DOWN: begin
                  if (b == lo_q) begin
                    b_n    = hi_q;
                    wrap_n = 1'b1;
                  end else begin
                    b_n = b - 1'b1;
                  end
                end
                M_BOUNCE: begin
                  // Endpoints turn around instead of repeating.
                  if (lo_q == hi_q) begin
                    wrap_n = 1'b1;
                  end else if (dir_up) begin
                    if (b == hi_q) begin
                      dir_n = 1'b0;
                      b_n   = b - 1'b1;
                    end else begin
                      b_n = b + 1'b1;
                    end
                  end else begin
                    if (b == lo_q) begin
                      dir_n  = 1'b1;
                      b_n    = b + 1'b1;
                      wrap_n = 1'b1;
                    end else begin
                      b_n = b - 1'b1;
                    end
                  end
                end
                M_SINGLE: begin
                  if (b == hi_q) begin
                    st_n   = S_DONE;
                    done_n = 1'b1;
                  end else begin
                    b_n = b + 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        S_HOLD: begin
          if (!hold) st_n = S_RUN;
        end
        S_DONE: st_n = S_IDLE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      st     <= S_IDLE;
      b      <= '0;
      dir_up <= 1'b1;
      en     <= 1'b0;
      busy   <= 1'b0;
      wrap   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      mode_q <= M_UP;
      lo_q   <= '0;
      hi_q   <= '0;
    end else begin
      st     <= st_n;
      b      <= b_n;
      dir_up <= dir_n;
      en     <= (st_n == S_RUN);
      busy   <= (st_n == S_RUN) || (st_n == S_HOLD);
      wrap   <= wrap_n;
      done   <= done_n;
      err    <= err_n;
      if (load) begin
        mode_q <= mode_t'(mode);
        lo_q   <= lo;
        hi_q   <= hi;
      end
    end
  end

endmodule

// File: tb/tb_seq_step4.sv
// Directed bench for seq_step4: one task per scenario, inline checks.
module tb_seq_step4;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start, stop, hold;
  logic [1:0] mode;
  logic [3:0] lo, hi;
  logic [7:0] period;
  logic [3:0] b;
  logic       en, busy, wrap, done, err;

  int n_tests = 0;
  int n_fail  = 0;

  seq_step4 #(.DIV_W(8)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .hold    (hold),
    .mode    (mode),
    .lo      (lo),
    .hi      (hi),
    .period  (period),
    .b       (b),
    .en      (en),
    .busy    (busy),
    .wrap    (wrap),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic go(input logic [1:0] m, input logic [3:0] l,
                    input logic [3:0] h, input logic [7:0] p);
    mode = m; lo = l; hi = h; period = p; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    start = 0; stop = 0; hold = 0;
    mode = 0; lo = 0; hi = 0; period = 0;
    #2;
    n_tests++;
    if ({b, en, busy, wrap, done, err} !== 9'd0) begin
      n_fail++;
      $display("FAIL reset_outs: got %b want 0", {b, en, busy, wrap, done, err});
    end
    cyc(); cyc();
    reset_n = 1'b1;
    cyc();
    n_tests++;
    if (en !== 1'b0 || b !== 4'd0) begin
      n_fail++;
      $display("FAIL reset_idle: got b=%0d en=%b want b=0 en=0", b, en);
    end
  endtask

  task automatic test_up_wrap();
    logic [3:0] eb [0:8];
    eb = '{4'd3, 4'd3, 4'd4, 4'd4, 4'd5, 4'd5, 4'd6, 4'd6, 4'd3};
    go(2'b00, 4'd3, 4'd6, 8'd1);
    for (int i = 0; i < 9; i++) begin
      if (i > 0) cyc();
      n_tests++;
      if (b !== eb[i] || en !== 1'b1 || wrap !== (i == 8)) begin
        n_fail++;
        $display("FAIL up_wrap[%0d]: got b=%0d en=%b wrap=%b want b=%0d en=1 wrap=%b",
                 i, b, en, wrap, eb[i], (i == 8));
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
    n_tests++;
    if (en !== 1'b0 || busy !== 1'b0 || b !== 4'd3) begin
      n_fail++;
      $display("FAIL up_stop: got en=%b busy=%b b=%0d want 0 0 3", en, busy, b);
    end
  endtask

  task automatic test_bounce();
    logic [3:0] eb [0:7];
    eb = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd2, 4'd1, 4'd0, 4'd1};
    go(2'b10, 4'd0, 4'd3, 8'd0);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) cyc();
      n_tests++;
      if (b !== eb[i] || wrap !== (i == 7)) begin
        n_fail++;
        $display("FAIL bounce[%0d]: got b=%0d wrap=%b want b=%0d wrap=%b",
                 i, b, wrap, eb[i], (i == 7));
      end
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_single();
    logic [3:0] eb [0:5];
    logic       ee [0:5];
    logic       ed [0:5];
    eb = '{4'd13, 4'd14, 4'd15, 4'd15, 4'd15, 4'd15};
    ee = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    ed = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    go(2'b11, 4'd13, 4'd15, 8'd0);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) cyc();
      n_tests++;
      if (b !== eb[i] || en !== ee[i] || done !== ed[i]) begin
        n_fail++;
        $display("FAIL single[%0d]: got b=%0d en=%b done=%b want b=%0d en=%b done=%b",
                 i, b, en, done, eb[i], ee[i], ed[i]);
      end
    end
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_hold();
    go(2'b00, 4'd0, 4'd7, 8'd3);
    cyc(); cyc();
    hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      n_tests++;
      if (en !== 1'b0 || busy !== 1'b1 || b !== 4'd0) begin
        n_fail++;
        $display("FAIL hold[%0d]: got en=%b busy=%b b=%0d want 0 1 0", i, en, busy, b);
      end
    end
    hold = 1'b0;
    cyc();
    n_tests++;
    if (en !== 1'b1 || b !== 4'd0) begin
      n_fail++;
      $display("FAIL hold_rel: got en=%b b=%0d want en=1 b=0", en, b);
    end
    cyc();
    n_tests++;
    if (b !== 4'd0) begin
      n_fail++;
      $display("FAIL hold_remain: got b=%0d want 0", b);
    end
    cyc();
    n_tests++;
    if (b !== 4'd1) begin
      n_fail++;
      $display("FAIL hold_step: got b=%0d want 1", b);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_err_stop();
    go(2'b00, 4'd9, 4'd4, 8'd0);
    n_tests++;
    if (err !== 1'b1 || en !== 1'b0 || busy !== 1'b0 || b !== 4'd1) begin
      n_fail++;
      $display("FAIL err_pulse: got err=%b en=%b busy=%b b=%0d want 1 0 0 1",
               err, en, busy, b);
    end
    cyc();
    n_tests++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL err_clear: got err=%b busy=%b want 0 0", err, busy);
    end
    go(2'b00, 4'd2, 4'd5, 8'd0);
    n_tests++;
    if (b !== 4'd2 || en !== 1'b1) begin
      n_fail++;
      $display("FAIL err_run: got b=%0d en=%b want 2 1", b, en);
    end
    lo = 4'd7; hi = 4'd9;
    stop = 1'b1; start = 1'b1;
    cyc();
    stop = 1'b0; start = 1'b0;
    n_tests++;
    if (en !== 1'b0 || busy !== 1'b0 || b !== 4'd2) begin
      n_fail++;
      $display("FAIL stop_wins: got en=%b busy=%b b=%0d want 0 0 2", en, busy, b);
    end
  endtask

  task automatic test_equal_restart();
    go(2'b10, 4'd5, 4'd5, 8'd0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_tests++;
      if (b !== 4'd5 || wrap !== 1'b1) begin
        n_fail++;
        $display("FAIL eq_bounce[%0d]: got b=%0d wrap=%b want 5 1", i, b, wrap);
      end
    end
    go(2'b01, 4'd2, 4'd4, 8'd0);
    n_tests++;
    if (b !== 4'd4 || wrap !== 1'b0) begin
      n_fail++;
      $display("FAIL restart_load: got b=%0d wrap=%b want 4 0", b, wrap);
    end
    cyc(); cyc(); cyc();
    n_tests++;
    if (b !== 4'd4 || wrap !== 1'b1) begin
      n_fail++;
      $display("FAIL down_wrap: got b=%0d wrap=%b want 4 1", b, wrap);
    end
    stop = 1'b1; cyc(); stop = 1'b0;
  endtask

  task automatic test_reset_mid();
    go(2'b00, 4'd10, 4'd12, 8'd7);
    cyc(); cyc();
    n_tests++;
    if (b !== 4'd10 || en !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_run: got b=%0d en=%b want 10 1", b, en);
    end
    #2 reset_n = 1'b0;
    #1;
    n_tests++;
    if (b !== 4'd0 || en !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL async_rst: got b=%0d en=%b busy=%b want 0 0 0", b, en, busy);
    end
    #3 reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      n_tests++;
      if (b !== 4'd0 || en !== 1'b0 || busy !== 1'b0 || wrap !== 1'b0) begin
        n_fail++;
        $display("FAIL post_rst[%0d]: got b=%0d en=%b busy=%b wrap=%b want all 0",
                 i, b, en, busy, wrap);
      end
    end
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_bounce();
    test_single();
    test_hold();
    test_err_stop();
    test_equal_restart();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
